nios_sysid_regs: RTL

- Parametrised system-identification slave on the Avalon-MM control bus; successor to the fixed two-word sysid block.
- Returns a build ID, a build timestamp and a capability word.
- Adds a 64-bit free-running uptime counter with coherent hi/lo snapshot, plus software-writable scratch registers for bus sanity checks.
- Registered read path: one-cycle read latency with readdatavalid.

---
 rtl/nios_sysid_regs.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/nios_sysid_regs.sv
// rtl/nios_sysid_regs.sv - system-id slave: ID, timestamp, caps, uptime (SYSID_UPTIME_EN), scratch
module nios_sysid_regs #(
    parameter logic [31:0] ID_VALUE        = 32'h00000000,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'd1461568625,
    parameter logic [15:0] VERSION         = 16'h0002,
    parameter int          ADDR_WIDTH      = 4,
    parameter int          NUM_SCRATCH     = 4,
    parameter logic [31:0] SCRATCH_RESET   = 32'h00000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic                  readdatavalid
);

    localparam logic [31:0] SCR_BASE = 32'd5;

    // A read that collides with a write is dropped; the write wins.
    logic        rd_accept;
    logic [31:0] addr_ext;
    logic [31:0] scratch_rdata;
    logic [31:0] uptime_lo_rdata;
    logic [31:0] uptime_hi_rdata;
    logic        uptime_present;
    logic [31:0] caps_word;
    logic [31:0] rdata_mux;

    assign rd_accept = read & ~write;
    assign addr_ext  = 32'(address);

`ifdef SYSID_UPTIME_EN
    logic [63:0] uptime_q, uptime_d;
    logic [31:0] uptime_hi_q, uptime_hi_d;

    // Free-running counter; an UPTIME_LO read freezes the upper half for a coherent pair.
    always_comb begin
        uptime_d    = uptime_q + 64'd1;
        uptime_hi_d = uptime_hi_q;
        if (rd_accept && addr_ext == 32'd3) begin
            uptime_hi_d = uptime_q[63:32];
        end
    end

    // Counter and snapshot state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_q    <= 64'd0;
            uptime_hi_q <= 32'd0;
        end else begin
            uptime_q    <= uptime_d;
            uptime_hi_q <= uptime_hi_d;
        end
    end

    assign uptime_lo_rdata = uptime_q[31:0];
    assign uptime_hi_rdata = uptime_hi_q;
    assign uptime_present  = 1'b1;
`else
    assign uptime_lo_rdata = 32'd0;
    assign uptime_hi_rdata = 32'd0;
    assign uptime_present  = 1'b0;
`endif

    generate
        if (NUM_SCRATCH > 0) begin : g_scratch
            logic [31:0] scratch_q [NUM_SCRATCH];
            logic [31:0] scratch_d [NUM_SCRATCH];

            // Byte-lane merge of writes into the addressed scratch word.
            always_comb begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    scratch_d[i] = scratch_q[i];
                    if (write && addr_ext == SCR_BASE + 32'(i)) begin
                        for (int k = 0; k < 4; k++) begin
                            if (byteenable[k]) begin
                                scratch_d[i][8*k +: 8] = writedata[8*k +: 8];
                            end
                        end
                    end
                end
            end

            // Scratch storage.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        scratch_q[i] <= SCRATCH_RESET;
                    end
                end else begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        scratch_q[i] <= scratch_d[i];
                    end
                end
            end

            // Scratch read select; zero when the address is outside the scratch window.
            always_comb begin
                scratch_rdata = 32'd0;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (addr_ext == SCR_BASE + 32'(i)) begin
                        scratch_rdata = scratch_q[i];
                    end
                end
            end
        end else begin : g_no_scratch
            assign scratch_rdata = 32'd0;
        end
    endgenerate

    assign caps_word = {VERSION, 7'd0, uptime_present, 8'(NUM_SCRATCH)};

    logic [31:0] readdata_q, readdata_d;
    logic        readdatavalid_q, readdatavalid_d;

    // Register map decode and read-data hold.
    always_comb begin
        case (addr_ext)
            32'd0:   rdata_mux = ID_VALUE;
            32'd1:   rdata_mux = TIMESTAMP_VALUE;
            32'd2:   rdata_mux = caps_word;
            32'd3:   rdata_mux = uptime_lo_rdata;
            32'd4:   rdata_mux = uptime_hi_rdata;
            default: rdata_mux = scratch_rdata;
        endcase
        readdata_d      = rd_accept ? rdata_mux : readdata_q;
        readdatavalid_d = rd_accept;
    end

    // Registered read response; reset discards any pending result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q      <= 32'd0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule
